// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared encodings for the multicycle MIPS control unit
// State, opcode/funct, mux-select encodings and interrupt vector addresses.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_INTR    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  typedef logic [2:0] pcsrc_t;
  typedef logic [1:0] m2r_t;
  typedef logic [1:0] regdst_t;
  typedef logic [1:0] srcb_t;
  typedef logic [1:0] aluop_t;
  typedef logic [1:0] brcond_t;

  localparam pcsrc_t PCSRC_ALU    = 3'b000;
  localparam pcsrc_t PCSRC_ALUOUT = 3'b001;
  localparam pcsrc_t PCSRC_JUMP   = 3'b010;
  localparam pcsrc_t PCSRC_JR     = 3'b011;
  localparam pcsrc_t PCSRC_NMI    = 3'b100;
  localparam pcsrc_t PCSRC_INT    = 3'b101;

  localparam m2r_t M2R_ALUOUT = 2'b00;
  localparam m2r_t M2R_MEM    = 2'b01;
  localparam m2r_t M2R_PC     = 2'b10;

  localparam regdst_t DST_RT  = 2'b00;
  localparam regdst_t DST_RD  = 2'b01;
  localparam regdst_t DST_RA  = 2'b10;
  localparam regdst_t DST_EPC = 2'b11;

  localparam srcb_t SRCB_RT     = 2'b00;
  localparam srcb_t SRCB_FOUR   = 2'b01;
  localparam srcb_t SRCB_IMM    = 2'b10;
  localparam srcb_t SRCB_IMM_SH = 2'b11;

  localparam aluop_t ALUOP_ADD  = 2'b00;
  localparam aluop_t ALUOP_SUB  = 2'b01;
  localparam aluop_t ALUOP_FUNC = 2'b10;

  localparam brcond_t BR_NONE = 2'b00;
  localparam brcond_t BR_EQ   = 2'b01;
  localparam brcond_t BR_NE   = 2'b10;

  localparam logic [31:0] NMI_VECTOR = 32'h8000_0180;
  localparam logic [31:0] INT_VECTOR = 32'h8000_0200;

  typedef struct packed {
    logic    pc_write;
    logic    lor_d;
    logic    mem_write;
    m2r_t    mem_to_reg;
    logic    ir_write;
    pcsrc_t  pc_src;
    aluop_t  alu_op;
    srcb_t   alu_src_b;
    logic    alu_src_a;
    logic    reg_write;
    regdst_t reg_dst;
    logic    branch;
    brcond_t br_cond;
  } ctrl_t;

endpackage

// File: rtl/controller_if.sv
// rtl/controller_if.sv - instruction fields, interrupt requests and datapath controls
// master is the control unit side, slave is the datapath side.
interface controller_if;
  import controller_pkg::*;

  logic [5:0] Op;
  logic [5:0] Func;
  logic       INT;
  logic       NMI;
  logic       INT_FLAG;
  logic       PCWrite;
  logic       lorD;
  logic       MemWrite;
  m2r_t       MemtoReg;
  logic       IRWrite;
  pcsrc_t     PCSrc;
  aluop_t     ALUOp;
  srcb_t      ALUSrcB;
  logic       ALUSrcA;
  logic       RegWrite;
  regdst_t    RegDst;
  logic       Branch;
  brcond_t    BRANCH_EQ_NQ;

  modport master (
    input  Op, Func, INT, NMI, INT_FLAG,
    output PCWrite, lorD, MemWrite, MemtoReg, IRWrite, PCSrc, ALUOp,
           ALUSrcB, ALUSrcA, RegWrite, RegDst, Branch, BRANCH_EQ_NQ
  );

  modport slave (
    output Op, Func, INT, NMI, INT_FLAG,
    input  PCWrite, lorD, MemWrite, MemtoReg, IRWrite, PCSrc, ALUOp,
           ALUSrcB, ALUSrcA, RegWrite, RegDst, Branch, BRANCH_EQ_NQ
  );
endinterface

// File: rtl/controller.sv
// rtl/controller.sv - Moore multicycle MIPS control FSM with NMI/INT entry
// Outputs decode from state only; interrupts divert between instructions.
module controller
  import controller_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst_n,
  controller_if.master  bus
);

  state_t state, state_next, end_state;
  ctrl_t  c;
  logic   nmi_pend, int_pend;
  logic   intr_nmi, is_bne;
  logic   nmi_in, int_in;
  logic   serviceable;

  assign nmi_in      = bus.NMI;
  assign int_in      = bus.INT;
  assign serviceable = nmi_pend | (int_pend & bus.INT_FLAG);
  assign end_state   = serviceable ? S_INTR : S_FETCH;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Remember branch flavour and interrupt source so later states need not resample Op/pending.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      is_bne   <= 1'b0;
      intr_nmi <= 1'b0;
    end else begin
      if (state == S_DECODE)    is_bne   <= (bus.Op == OP_BNE);
      if (state_next == S_INTR) intr_nmi <= nmi_pend;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_RTYPE:      state_next = (bus.Func == FUNC_JR) ? S_JR : S_EXECUTE;
          OP_LW, OP_SW:  state_next = S_MEMADR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:       state_next = S_ADDIEX;
          OP_J:          state_next = S_JUMP;
          OP_JAL:        state_next = S_JAL;
          default:       state_next = end_state;
        endcase
      end
      S_MEMADR:  state_next = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JAL, S_JR:
                 state_next = end_state;
      S_INTR:    state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    if (Rst_n) begin
      case (state)
        S_FETCH: begin
          c.ir_write  = 1'b1;
          c.pc_write  = 1'b1;
          c.alu_src_b = SRCB_FOUR;
          c.pc_src    = PCSRC_ALU;
          c.alu_op    = ALUOP_ADD;
        end
        S_DECODE: c.alu_src_b = SRCB_IMM_SH;
        S_MEMADR, S_ADDIEX: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: c.lor_d = 1'b1;
        S_MEMWB: begin
          c.reg_write  = 1'b1;
          c.reg_dst    = DST_RT;
          c.mem_to_reg = M2R_MEM;
        end
        S_MEMWR: begin
          c.lor_d     = 1'b1;
          c.mem_write = 1'b1;
        end
        S_EXECUTE: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_RT;
          c.alu_op    = ALUOP_FUNC;
        end
        S_ALUWB: begin
          c.reg_write  = 1'b1;
          c.reg_dst    = DST_RD;
          c.mem_to_reg = M2R_ALUOUT;
        end
        S_BRANCH: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_RT;
          c.alu_op    = ALUOP_SUB;
          c.pc_src    = PCSRC_ALUOUT;
          c.branch    = 1'b1;
          c.br_cond   = is_bne ? BR_NE : BR_EQ;
        end
        S_ADDIWB: begin
          c.reg_write  = 1'b1;
          c.reg_dst    = DST_RT;
          c.mem_to_reg = M2R_ALUOUT;
        end
        S_JUMP: begin
          c.pc_write = 1'b1;
          c.pc_src   = PCSRC_JUMP;
        end
        S_JAL: begin
          c.pc_write   = 1'b1;
          c.pc_src     = PCSRC_JUMP;
          c.reg_write  = 1'b1;
          c.reg_dst    = DST_RA;
          c.mem_to_reg = M2R_PC;
        end
        S_JR: begin
          c.pc_write = 1'b1;
          c.pc_src   = PCSRC_JR;
        end
        S_INTR: begin
          c.reg_write  = 1'b1;
          c.reg_dst    = DST_EPC;
          c.mem_to_reg = M2R_PC;
          c.pc_write   = 1'b1;
          c.pc_src     = intr_nmi ? PCSRC_NMI : PCSRC_INT;
        end
        default: c = '0;
      endcase
    end
  end

  assign bus.PCWrite      = c.pc_write;
  assign bus.lorD         = c.lor_d;
  assign bus.MemWrite     = c.mem_write;
  assign bus.MemtoReg     = c.mem_to_reg;
  assign bus.IRWrite      = c.ir_write;
  assign bus.PCSrc        = c.pc_src;
  assign bus.ALUOp        = c.alu_op;
  assign bus.ALUSrcB      = c.alu_src_b;
  assign bus.ALUSrcA      = c.alu_src_a;
  assign bus.RegWrite     = c.reg_write;
  assign bus.RegDst       = c.reg_dst;
  assign bus.Branch       = c.branch;
  assign bus.BRANCH_EQ_NQ = c.br_cond;

  // Request level acts as an async set so pulses shorter than a clock are still caught.
  always_ff @(posedge Clk or negedge Rst_n or posedge nmi_in) begin
    if (!Rst_n)                             nmi_pend <= 1'b0;
    else if (nmi_in)                        nmi_pend <= 1'b1;
    else if (state == S_INTR && intr_nmi)   nmi_pend <= 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n or posedge int_in) begin
    if (!Rst_n)                             int_pend <= 1'b0;
    else if (int_in)                        int_pend <= 1'b1;
    else if (state == S_INTR && !intr_nmi)  int_pend <= 1'b0;
  end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - scoreboard bench for the multicycle control unit
`timescale 1ns/1ps
module tb_controller;

  typedef struct {
    logic [19:0] w;
    string       name;
  } exp_t;

  function automatic logic [19:0] mk(
    input logic pcw, input logic lord, input logic memw, input logic [1:0] m2r,
    input logic irw, input logic [2:0] pcsrc, input logic [1:0] aluop,
    input logic [1:0] srcb, input logic srca, input logic regw,
    input logic [1:0] dst, input logic br, input logic [1:0] breq);
    return {pcw, lord, memw, m2r, irw, pcsrc, aluop, srcb, srca, regw, dst, br, breq};
  endfunction

  localparam logic [19:0] W_ZERO   = 20'h0;
  localparam logic [19:0] W_FETCH  = mk(1,0,0,2'b00,1,3'b000,2'b00,2'b01,0,0,2'b00,0,2'b00);
  localparam logic [19:0] W_DECODE = mk(0,0,0,2'b00,0,3'b000,2'b00,2'b11,0,0,2'b00,0,2'b00);
  localparam logic [19:0] W_EXEC   = mk(0,0,0,2'b00,0,3'b000,2'b10,2'b00,1,0,2'b00,0,2'b00);
  localparam logic [19:0] W_ALUWB  = mk(0,0,0,2'b00,0,3'b000,2'b00,2'b00,0,1,2'b01,0,2'b00);
  localparam logic [19:0] W_MEMADR = mk(0,0,0,2'b00,0,3'b000,2'b00,2'b10,1,0,2'b00,0,2'b00);
  localparam logic [19:0] W_MEMRD  = mk(0,1,0,2'b00,0,3'b000,2'b00,2'b00,0,0,2'b00,0,2'b00);
  localparam logic [19:0] W_MEMWB  = mk(0,0,0,2'b01,0,3'b000,2'b00,2'b00,0,1,2'b00,0,2'b00);
  localparam logic [19:0] W_MEMWR  = mk(0,1,1,2'b00,0,3'b000,2'b00,2'b00,0,0,2'b00,0,2'b00);
  localparam logic [19:0] W_BNE    = mk(0,0,0,2'b00,0,3'b001,2'b01,2'b00,1,0,2'b00,1,2'b10);
  localparam logic [19:0] W_BEQ    = mk(0,0,0,2'b00,0,3'b001,2'b01,2'b00,1,0,2'b00,1,2'b01);
  localparam logic [19:0] W_ADDIEX = mk(0,0,0,2'b00,0,3'b000,2'b00,2'b10,1,0,2'b00,0,2'b00);
  localparam logic [19:0] W_ADDIWB = mk(0,0,0,2'b00,0,3'b000,2'b00,2'b00,0,1,2'b00,0,2'b00);
  localparam logic [19:0] W_JUMP   = mk(1,0,0,2'b00,0,3'b010,2'b00,2'b00,0,0,2'b00,0,2'b00);
  localparam logic [19:0] W_JAL    = mk(1,0,0,2'b10,0,3'b010,2'b00,2'b00,0,1,2'b10,0,2'b00);
  localparam logic [19:0] W_JR     = mk(1,0,0,2'b00,0,3'b011,2'b00,2'b00,0,0,2'b00,0,2'b00);
  localparam logic [19:0] W_INMI   = mk(1,0,0,2'b10,0,3'b100,2'b00,2'b00,0,1,2'b11,0,2'b00);
  localparam logic [19:0] W_IINT   = mk(1,0,0,2'b10,0,3'b101,2'b00,2'b00,0,1,2'b11,0,2'b00);

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  controller_if bus ();

  controller dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  logic [19:0] act;
  assign act = {bus.PCWrite, bus.lorD, bus.MemWrite, bus.MemtoReg, bus.IRWrite,
                bus.PCSrc, bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, bus.RegWrite,
                bus.RegDst, bus.Branch, bus.BRANCH_EQ_NQ};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e.w) begin
        failures++;
        $display("FAIL %s actual=%05h expected=%05h", e.name, act, e.w);
      end
    end
  end

  task automatic push(input logic [19:0] w, input string name);
    exp_t e;
    e.w = w;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, a, e);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; n cycles are run, optional pulse in cycle pulse_cyc.
  task automatic run(input logic [5:0] op, input logic [5:0] func, input int n,
                     input int pulse_cyc, input logic p_nmi, input logic p_int);
    bus.Op = op;
    bus.Func = func;
    for (int c = 0; c < n; c++) begin
      if (c == pulse_cyc) begin
        #19;
        bus.NMI = p_nmi;
        bus.INT = p_int;
        #50;
        bus.NMI = 1'b0;
        bus.INT = 1'b0;
      end
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.Op = 6'b100011;
    bus.Func = 6'b0;
    bus.INT = 1'b0;
    bus.NMI = 1'b0;
    bus.INT_FLAG = 1'b1;

    push(W_ZERO, "reset_outputs");
    @(posedge clk); #1;
    check_bit("reset_nmi_pend", dut.nmi_pend, 1'b0);
    check_bit("reset_int_pend", dut.int_pend, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.INT_FLAG = 1'b0;

    push(W_FETCH, "r_fetch"); push(W_DECODE, "r_decode");
    push(W_EXEC, "r_execute"); push(W_ALUWB, "r_aluwb");
    run(6'b000000, 6'b100000, 4, -1, 0, 0);

    push(W_FETCH, "lw_fetch"); push(W_DECODE, "lw_decode"); push(W_MEMADR, "lw_memadr");
    push(W_MEMRD, "lw_memrd"); push(W_MEMWB, "lw_memwb");
    run(6'b100011, 6'b0, 5, -1, 0, 0);

    push(W_FETCH, "sw_fetch"); push(W_DECODE, "sw_decode");
    push(W_MEMADR, "sw_memadr"); push(W_MEMWR, "sw_memwr");
    run(6'b101011, 6'b0, 4, -1, 0, 0);

    push(W_FETCH, "bne_fetch"); push(W_DECODE, "bne_decode"); push(W_BNE, "bne_branch");
    run(6'b000101, 6'b0, 3, -1, 0, 0);

    push(W_FETCH, "beq_fetch"); push(W_DECODE, "beq_decode"); push(W_BEQ, "beq_branch");
    run(6'b000100, 6'b0, 3, -1, 0, 0);

    push(W_FETCH, "jal_fetch"); push(W_DECODE, "jal_decode"); push(W_JAL, "jal_state");
    run(6'b000011, 6'b0, 3, -1, 0, 0);

    push(W_FETCH, "jr_fetch"); push(W_DECODE, "jr_decode"); push(W_JR, "jr_state");
    run(6'b000000, 6'b001000, 3, -1, 0, 0);

    push(W_FETCH, "addi_fetch"); push(W_DECODE, "addi_decode");
    push(W_ADDIEX, "addi_ex"); push(W_ADDIWB, "addi_wb");
    run(6'b001000, 6'b0, 4, -1, 0, 0);

    push(W_FETCH, "nop_fetch"); push(W_DECODE, "nop_decode");
    run(6'b111111, 6'b0, 2, -1, 0, 0);

    // NMI pulse during DECODE of an R-type
    push(W_FETCH, "nmi_fetch"); push(W_DECODE, "nmi_decode"); push(W_EXEC, "nmi_execute");
    push(W_ALUWB, "nmi_aluwb"); push(W_INMI, "nmi_intr");
    run(6'b000000, 6'b100000, 5, 1, 1, 0);
    check_bit("nmi_pend_cleared", dut.nmi_pend, 1'b0);

    // NMI on an unknown opcode diverts straight from DECODE
    push(W_FETCH, "nopnmi_fetch"); push(W_DECODE, "nopnmi_decode"); push(W_INMI, "nopnmi_intr");
    run(6'b111111, 6'b0, 3, 0, 1, 0);

    // masked INT stays pending
    push(W_FETCH, "mask_fetch"); push(W_DECODE, "mask_decode");
    push(W_EXEC, "mask_execute"); push(W_ALUWB, "mask_aluwb");
    run(6'b000000, 6'b100000, 4, 0, 0, 1);
    check_bit("int_pend_masked", dut.int_pend, 1'b1);
    push(W_FETCH, "mask_j_fetch"); push(W_DECODE, "mask_j_decode"); push(W_JUMP, "mask_j_jump");
    run(6'b000010, 6'b0, 3, -1, 0, 0);

    bus.INT_FLAG = 1'b1;
    push(W_FETCH, "unmask_fetch"); push(W_DECODE, "unmask_decode"); push(W_ADDIEX, "unmask_ex");
    push(W_ADDIWB, "unmask_wb"); push(W_IINT, "unmask_intr");
    run(6'b001000, 6'b0, 5, -1, 0, 0);
    check_bit("int_pend_cleared", dut.int_pend, 1'b0);

    // simultaneous NMI+INT: NMI first, INT after one more instruction
    push(W_FETCH, "both_fetch"); push(W_DECODE, "both_decode"); push(W_EXEC, "both_execute");
    push(W_ALUWB, "both_aluwb"); push(W_INMI, "both_intr_nmi");
    run(6'b000000, 6'b100000, 5, 1, 1, 1);
    check_bit("both_int_still_pend", dut.int_pend, 1'b1);
    push(W_FETCH, "both_j_fetch"); push(W_DECODE, "both_j_decode");
    push(W_JUMP, "both_j_jump"); push(W_IINT, "both_intr_int");
    run(6'b000010, 6'b0, 4, -1, 0, 0);
    push(W_FETCH, "after_fetch"); push(W_DECODE, "after_decode");
    run(6'b111111, 6'b0, 2, -1, 0, 0);
    check_bit("final_nmi_pend", dut.nmi_pend, 1'b0);
    check_bit("final_int_pend", dut.int_pend, 1'b0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
